// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard decoder: scan codes, FSM encodings
// and the arrow-key lookup used by both make and break handling.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_S     = 8'h1B;

  typedef enum logic {
    RX_IDLE,
    RX_RECV
  } rx_state_t;

  typedef enum logic [1:0] {
    DEC_BASE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_t;

  // One-hot direction for an arrow scan code ([3]=up ... [0]=right), 0 otherwise.
  function automatic logic [3:0] arrow_dir(input logic [7:0] code);
    logic [3:0] dir;
    dir = 4'b0000;
    case (code)
      SC_UP:    dir = 4'b1000;
      SC_DOWN:  dir = 4'b0100;
      SC_LEFT:  dir = 4'b0010;
      SC_RIGHT: dir = 4'b0001;
      default:  dir = 4'b0000;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes and deglitches the raw lines, then
// assembles 11-bit frames, checking odd parity, stop bit and inter-edge timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scancode,
  output logic       code_valid,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Bit 1 carries ps2_clk, bit 0 carries ps2_dat; both idle high on the bus.
  logic [1:0] raw_lines;
  logic [1:0] sync_lines;
  assign raw_lines = {ps2_clk, ps2_dat};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      // Two-flop synchronizer, reset to the bus idle level.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          s1_reg <= 1'b1;
          s2_reg <= 1'b1;
        end else begin
          s1_reg <= raw_lines[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sync_lines[gi] = s2_reg;
    end
  endgenerate

  logic clk_sync;
  logic dat_sync;
  assign clk_sync = sync_lines[1];
  assign dat_sync = sync_lines[0];

  logic          filt_level_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          fall;

  // Filtered clock flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_level_reg <= 1'b1;
      filt_cnt_reg   <= '0;
    end else if (clk_sync == filt_level_reg) begin
      filt_cnt_reg <= '0;
    end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
      filt_level_reg <= clk_sync;
      filt_cnt_reg   <= '0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + 1'b1;
    end
  end

  // Falling edge is the cycle in which the filtered level is about to drop.
  assign fall = filt_level_reg && !clk_sync && (filt_cnt_reg == FW'(FILTER_LEN - 1));

  rx_state_t     state_reg, state_next;
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_reg, parity_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic [7:0]    code_reg, code_next;
  logic          valid_reg, valid_next;
  logic          err_reg, err_next;

  // Receiver state and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= RX_IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      to_cnt_reg  <= '0;
      code_reg    <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      to_cnt_reg  <= to_cnt_next;
      code_reg    <= code_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
    end
  end

  // Frame sequencing: start, 8 data bits LSB first, parity at 9, stop at 10.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    to_cnt_next  = to_cnt_reg;
    code_next    = code_reg;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        to_cnt_next = '0;
        if (fall) begin
          if (!dat_sync) begin
            state_next   = RX_RECV;
            bit_cnt_next = 4'd1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      RX_RECV: begin
        if (fall) begin
          to_cnt_next  = '0;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg <= 4'd8) begin
            shift_next = {dat_sync, shift_reg[7:1]};
          end else if (bit_cnt_reg == 4'd9) begin
            parity_next = dat_sync;
          end else begin
            state_next   = RX_IDLE;
            bit_cnt_next = '0;
            if (dat_sync && (^{shift_reg, parity_reg})) begin
              code_next  = shift_reg;
              valid_next = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end
        end else if (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
          err_next     = 1'b1;
          state_next   = RX_IDLE;
          bit_cnt_next = '0;
          to_cnt_next  = '0;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign scancode    = code_reg;
  assign code_valid  = valid_reg;
  assign frame_error = err_reg;

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 arrow and S make codes into one-cycle direction / start pulses,
// suppressing typematic repeats until the matching break code arrives.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [3:0] direction,
  output logic       start_pulse,
  output logic [7:0] scancode,
  output logic       code_valid,
  output logic       frame_error
);

  ps2_rx_frame #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .scancode   (scancode),
    .code_valid (code_valid),
    .frame_error(frame_error)
  );

  // held[4:1] mirrors direction bit order (up, down, left, right); held[0] is S.
  dec_state_t state_reg, state_next;
  logic [4:0] held_reg, held_next;
  logic [3:0] dir_reg, dir_next;
  logic       start_reg, start_next;
  logic [3:0] code_dir;

  assign code_dir = arrow_dir(scancode);

  // Decoder state, held flags and registered output pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= DEC_BASE;
      held_reg  <= '0;
      dir_reg   <= '0;
      start_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      held_reg  <= held_next;
      dir_reg   <= dir_next;
      start_reg <= start_next;
    end
  end

  // Prefix tracking (E0 / F0) and make/break handling on each received byte.
  always_comb begin
    state_next = state_reg;
    held_next  = held_reg;
    dir_next   = 4'b0000;
    start_next = 1'b0;
    if (code_valid) begin
      case (state_reg)
        DEC_BASE: begin
          if (scancode == SC_EXT) begin
            state_next = DEC_EXT;
          end else if (scancode == SC_BRK) begin
            state_next = DEC_BRK;
          end else if (scancode == SC_S) begin
            start_next   = !held_reg[0];
            held_next[0] = 1'b1;
          end
        end
        DEC_EXT: begin
          if (scancode == SC_BRK) begin
            state_next = DEC_EXT_BRK;
          end else if (scancode != SC_EXT) begin
            state_next = DEC_BASE;
            if (code_dir != 4'b0000) begin
              dir_next       = code_dir & ~held_reg[4:1];
              held_next[4:1] = held_reg[4:1] | code_dir;
            end
          end
        end
        DEC_BRK: begin
          if (scancode != SC_BRK) begin
            state_next = DEC_BASE;
            if (scancode == SC_S) held_next[0] = 1'b0;
          end
        end
        DEC_EXT_BRK: begin
          state_next     = DEC_BASE;
          held_next[4:1] = held_reg[4:1] & ~code_dir;
        end
        default: state_next = DEC_BASE;
      endcase
    end
  end

  assign direction   = dir_reg;
  assign start_pulse = start_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: each scenario pushes the events it
// expects, and a monitor pops and compares every event the DUT produces.
module tb_ps2_key_decoder;

  localparam int H = 16;  // ps2_clk half period in system clocks
  localparam int TIMEOUT = 50000;
  localparam int EV_CODE = 0, EV_ERR = 1, EV_DIR = 2, EV_START = 3;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [3:0] direction;
  logic       start_pulse;
  logic [7:0] scancode;
  logic       code_valid;
  logic       frame_error;

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .direction  (direction),
    .start_pulse(start_pulse),
    .scancode   (scancode),
    .code_valid (code_valid),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int  n_checks = 0;
  int  n_fail = 0;
  int  cycle_cnt = 0;
  int  last_cv = -10;
  int  last_err = -1;
  ev_t exp_q[$];
  ev_t obs[4];
  ev_t exp_ev;
  int  n_obs;

  always @(posedge clock) cycle_cnt++;

  // Monitor: collect this cycle's events and compare each against the queue head.
  always @(negedge clock) begin
    if (!reset) begin
      n_obs = 0;
      if (code_valid) begin obs[n_obs] = '{EV_CODE, scancode}; n_obs++; last_cv = cycle_cnt; end
      if (frame_error) begin obs[n_obs] = '{EV_ERR, 8'h00}; n_obs++; last_err = cycle_cnt; end
      if (direction != 4'b0000) begin obs[n_obs] = '{EV_DIR, {4'b0000, direction}}; n_obs++; end
      if (start_pulse) begin obs[n_obs] = '{EV_START, 8'h00}; n_obs++; end
      for (int i = 0; i < n_obs; i++) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got kind=%0d val=%h at cycle %0d, required no event",
                   obs[i].kind, obs[i].val, cycle_cnt);
        end else begin
          exp_ev = exp_q.pop_front();
          if (exp_ev.kind !== obs[i].kind || exp_ev.val !== obs[i].val) begin
            n_fail++;
            $display("FAIL event: got kind=%0d val=%h, required kind=%0d val=%h",
                     obs[i].kind, obs[i].val, exp_ev.kind, exp_ev.val);
          end
        end
        if (obs[i].kind == EV_DIR || obs[i].kind == EV_START) begin
          n_checks++;
          if (cycle_cnt != last_cv + 1) begin
            n_fail++;
            $display("FAIL pulse_latency: got %0d cycles after code_valid, required 1",
                     cycle_cnt - last_cv);
          end
        end
      end
    end
  end

  task automatic push(input int kind, input logic [7:0] val);
    exp_q.push_back('{kind, val});
  endtask

  task automatic send_bit(input logic v);
    @(negedge clock) ps2_dat = v;
    repeat (H) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clock);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_parity);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    ps2_dat = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (5) @(negedge clock);
    n_checks++; if (direction !== 4'b0000) begin n_fail++; $display("FAIL reset_direction: got %b, required 0000", direction); end
    n_checks++; if (start_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b, required 0", start_pulse); end
    n_checks++; if (scancode !== 8'h00) begin n_fail++; $display("FAIL reset_scancode: got %h, required 00", scancode); end
    n_checks++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL reset_code_valid: got %b, required 0", code_valid); end
    n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error: got %b, required 0", frame_error); end
    reset = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_ext_make;
    push(EV_CODE, 8'hE0); send_frame(8'hE0, 0);
    push(EV_CODE, 8'h75); push(EV_DIR, 8'h08); send_frame(8'h75, 0);
    push(EV_CODE, 8'hE0); send_frame(8'hE0, 0);
    push(EV_CODE, 8'hF0); send_frame(8'hF0, 0);
    push(EV_CODE, 8'h75); send_frame(8'h75, 0);
    repeat (20) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL ext_make_drain: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_typematic;
    for (int r = 0; r < 3; r++) begin
      push(EV_CODE, 8'hE0); send_frame(8'hE0, 0);
      push(EV_CODE, 8'h75); if (r == 0) push(EV_DIR, 8'h08); send_frame(8'h75, 0);
    end
    push(EV_CODE, 8'hE0); send_frame(8'hE0, 0);
    push(EV_CODE, 8'hF0); send_frame(8'hF0, 0);
    push(EV_CODE, 8'h75); send_frame(8'h75, 0);
    push(EV_CODE, 8'hE0); send_frame(8'hE0, 0);
    push(EV_CODE, 8'h75); push(EV_DIR, 8'h08); send_frame(8'h75, 0);
    push(EV_CODE, 8'hE0); send_frame(8'hE0, 0);
    push(EV_CODE, 8'hF0); send_frame(8'hF0, 0);
    push(EV_CODE, 8'h75); send_frame(8'h75, 0);
    repeat (20) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL typematic_drain: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_start_and_keypad;
    push(EV_CODE, 8'h1B); push(EV_START, 8'h00); send_frame(8'h1B, 0);
    push(EV_CODE, 8'h1B); send_frame(8'h1B, 0);
    push(EV_CODE, 8'hF0); send_frame(8'hF0, 0);
    push(EV_CODE, 8'h1B); send_frame(8'h1B, 0);
    push(EV_CODE, 8'h75); send_frame(8'h75, 0);
    push(EV_CODE, 8'hE0); send_frame(8'hE0, 0);
    push(EV_CODE, 8'h6B); push(EV_DIR, 8'h02); send_frame(8'h6B, 0);
    push(EV_CODE, 8'hE0); send_frame(8'hE0, 0);
    push(EV_CODE, 8'h74); push(EV_DIR, 8'h01); send_frame(8'h74, 0);
    push(EV_CODE, 8'hE0); send_frame(8'hE0, 0);
    push(EV_CODE, 8'hF0); send_frame(8'hF0, 0);
    push(EV_CODE, 8'h6B); send_frame(8'h6B, 0);
    push(EV_CODE, 8'hE0); send_frame(8'hE0, 0);
    push(EV_CODE, 8'hF0); send_frame(8'hF0, 0);
    push(EV_CODE, 8'h74); send_frame(8'h74, 0);
    repeat (20) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL start_drain: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_parity_error;
    push(EV_CODE, 8'hE0); send_frame(8'hE0, 0);
    push(EV_ERR, 8'h00); send_frame(8'h6B, 1);
    n_checks++;
    if (scancode !== 8'hE0) begin n_fail++; $display("FAIL parity_scancode_kept: got %h, required e0", scancode); end
    push(EV_CODE, 8'h6B); push(EV_DIR, 8'h02); send_frame(8'h6B, 0);
    push(EV_CODE, 8'hE0); send_frame(8'hE0, 0);
    push(EV_CODE, 8'hF0); send_frame(8'hF0, 0);
    push(EV_CODE, 8'h6B); send_frame(8'h6B, 0);
    repeat (20) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL parity_drain: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_timeout;
    logic [10:0] f;
    int t_drop;
    f = {1'b1, ~^8'h1B, 8'h1B, 1'b0};
    push(EV_ERR, 8'h00);
    for (int i = 0; i < 4; i++) send_bit(f[i]);
    @(negedge clock) ps2_dat = f[4];
    repeat (H) @(negedge clock);
    ps2_clk = 1'b0;
    t_drop = cycle_cnt;
    repeat (H) @(negedge clock);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    last_err = -1;
    repeat (TIMEOUT + 100) @(negedge clock);
    n_checks++;
    if (last_err < t_drop + TIMEOUT || last_err > t_drop + TIMEOUT + 20) begin
      n_fail++;
      $display("FAIL timeout_time: got error %0d cycles after clock drop, required %0d..%0d",
               last_err - t_drop, TIMEOUT, TIMEOUT + 20);
    end
    push(EV_CODE, 8'h1B); push(EV_START, 8'h00); send_frame(8'h1B, 0);
    push(EV_CODE, 8'hF0); send_frame(8'hF0, 0);
    push(EV_CODE, 8'h1B); send_frame(8'h1B, 0);
    repeat (20) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL timeout_drain: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_glitch;
    @(negedge clock) ps2_clk = 1'b0;
    repeat (3) @(negedge clock);
    ps2_clk = 1'b1;
    repeat (40) @(negedge clock);
    // A real frame afterwards must still decode from bit 0.
    push(EV_CODE, 8'hE0); send_frame(8'hE0, 0);
    push(EV_CODE, 8'h72); push(EV_DIR, 8'h04); send_frame(8'h72, 0);
    repeat (20) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL glitch_drain: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_midframe;
    logic [10:0] f;
    f = {1'b1, ~^8'h75, 8'h75, 1'b0};
    push(EV_CODE, 8'hE0); send_frame(8'hE0, 0);
    for (int i = 0; i < 6; i++) send_bit(f[i]);
    @(negedge clock) ps2_dat = f[6];
    repeat (H) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++; if (scancode !== 8'h00) begin n_fail++; $display("FAIL midreset_scancode: got %h, required 00", scancode); end
    n_checks++; if (direction !== 4'b0000 || start_pulse !== 1'b0) begin n_fail++; $display("FAIL midreset_pulses: got dir=%b start=%b, required 0000/0", direction, start_pulse); end
    n_checks++; if (code_valid !== 1'b0 || frame_error !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got cv=%b fe=%b, required 0/0", code_valid, frame_error); end
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL midreset_pre_drain: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
    // Down was held before reset; a fresh pulse shows held was cleared.
    push(EV_CODE, 8'hE0); send_frame(8'hE0, 0);
    push(EV_CODE, 8'h72); push(EV_DIR, 8'h04); send_frame(8'h72, 0);
    push(EV_CODE, 8'hE0); send_frame(8'hE0, 0);
    push(EV_CODE, 8'h75); push(EV_DIR, 8'h08); send_frame(8'h75, 0);
    repeat (20) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL midreset_drain: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_ext_make();
    test_typematic();
    test_start_and_keypad();
    test_parity_error();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
